handshake_sink_checker: RTL and testbench

HANDSHAKE_SINK_CHECKER -- requirements
Module: handshake_sink_checker

---
 rtl/handshake_sink_checker.sv | 177 +++++++++++++++++
 tb/tb_handshake_sink_checker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_sink_checker.sv
// Ready/valid sink that paces acceptance with a configurable ready pattern,
// checks an incrementing data stream and flags upstream protocol violations.
module handshake_sink_checker #(
   parameter int WORD_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [WORD_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  start,
   input  logic [1:0]            cfg_mode,
   input  logic [15:0]           cfg_seed,
   input  logic [WORD_WIDTH-1:0] cfg_first,
   input  logic [CNT_WIDTH-1:0]  cfg_num_beats,
   output logic [CNT_WIDTH-1:0]  beat_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  data_err,
   output logic                  proto_err,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam logic [1:0]  MODE_ALWAYS = 2'b00;
   localparam logic [1:0]  MODE_TOGGLE = 2'b01;
   localparam logic [1:0]  MODE_LFSR   = 2'b10;
   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   state_t                r_state;
   logic                  r_in_ready;
   logic [1:0]            r_mode;
   logic [CNT_WIDTH-1:0]  r_num_beats;
   logic [CNT_WIDTH-1:0]  r_beat_cnt;
   logic [CNT_WIDTH-1:0]  r_err_cnt;
   logic                  r_data_err;
   logic                  r_proto_err;
   logic [WORD_WIDTH-1:0] r_expected;
   logic [15:0]           r_lfsr;
   logic                  r_prev_stall;
   logic [WORD_WIDTH-1:0] r_prev_data;

   state_t                w_state_nxt;
   logic                  w_load;
   logic                  w_ready_nxt;
   logic                  w_beat;
   logic                  w_mismatch;
   logic                  w_proto_viol;
   logic [15:0]           w_seed;
   logic [15:0]           w_lfsr_nxt;
   logic [CNT_WIDTH-1:0]  w_beat_cnt_inc;
   logic [CNT_WIDTH-1:0]  w_err_cnt_inc;

   assign w_beat         = (r_state == ST_RUN) && in_valid && r_in_ready;
   assign w_mismatch     = (in_data != r_expected);
   assign w_seed         = (cfg_seed == 16'h0000) ? LFSR_DEFAULT : cfg_seed;
   // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
   assign w_lfsr_nxt     = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
   assign w_beat_cnt_inc = sat_inc(r_beat_cnt);
   assign w_err_cnt_inc  = sat_inc(r_err_cnt);
   // A stalled beat must be held: dropping valid or changing data is illegal.
   assign w_proto_viol   = (r_state == ST_RUN) && r_prev_stall &&
                           (!in_valid || (in_data != r_prev_data));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ready_nxt = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = (cfg_num_beats == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_beat && (w_beat_cnt_inc == r_num_beats)) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_load && (w_state_nxt == ST_RUN)) begin
         case (cfg_mode)
            MODE_ALWAYS: w_ready_nxt = 1'b1;
            MODE_TOGGLE: w_ready_nxt = 1'b1;
            MODE_LFSR:   w_ready_nxt = w_seed[0];
            default:     w_ready_nxt = 1'b0;
         endcase
      end else if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
         case (r_mode)
            MODE_ALWAYS: w_ready_nxt = 1'b1;
            MODE_TOGGLE: w_ready_nxt = ~r_in_ready;
            MODE_LFSR:   w_ready_nxt = w_lfsr_nxt[0];
            default:     w_ready_nxt = 1'b0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: reset is synchronous, so it is sampled only on the clock edge and
   // overrides start by being the first branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in_ready   <= 1'b0;
         r_mode       <= '0;
         r_num_beats  <= '0;
         r_beat_cnt   <= '0;
         r_err_cnt    <= '0;
         r_data_err   <= 1'b0;
         r_proto_err  <= 1'b0;
         r_expected   <= '0;
         r_lfsr       <= LFSR_DEFAULT;
         r_prev_stall <= 1'b0;
         r_prev_data  <= '0;
      end else begin
         r_in_ready   <= w_ready_nxt;
         r_prev_stall <= in_valid && !r_in_ready;
         r_prev_data  <= in_data;
         if (w_load) begin
            r_mode      <= cfg_mode;
            r_num_beats <= cfg_num_beats;
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
            r_data_err  <= 1'b0;
            r_proto_err <= 1'b0;
            r_expected  <= cfg_first;
            r_lfsr      <= w_seed;
         end else if (r_state == ST_RUN) begin
            r_lfsr <= w_lfsr_nxt;
            if (w_beat) begin
               r_beat_cnt <= w_beat_cnt_inc;
               if (w_mismatch) begin
                  r_err_cnt  <= w_err_cnt_inc;
                  r_data_err <= 1'b1;
                  r_expected <= in_data + WORD_WIDTH'(1);
               end else begin
                  r_expected <= r_expected + WORD_WIDTH'(1);
               end
            end
            if (w_proto_viol) begin
               r_proto_err <= 1'b1;
            end
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign beat_cnt  = r_beat_cnt;
   assign err_cnt   = r_err_cnt;
   assign data_err  = r_data_err;
   assign proto_err = r_proto_err;
   assign busy      = (r_state == ST_RUN);
   assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_handshake_sink_checker.sv
// Directed bench: a driver issues beats and queues the expected counter values,
// a monitor pops and compares them after each observed handshake.
module tb_handshake_sink_checker;

   typedef struct {
      logic [15:0] beat;
      logic [15:0] err;
      logic        derr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        start = 1'b0;
   logic [1:0]  cfg_mode = '0;
   logic [15:0] cfg_seed = '0;
   logic [7:0]  cfg_first = '0;
   logic [15:0] cfg_num_beats = '0;
   logic [15:0] beat_cnt;
   logic [15:0] err_cnt;
   logic        data_err;
   logic        proto_err;
   logic        busy;
   logic        done;

   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        sb_q[$];
   logic [7:0]  tx_data[$];
   exp_t        tx_exp[$];
   bit          hs_pend = 1'b0;
   logic [63:0] cap = '0;
   int          ncap = 0;

   handshake_sink_checker #(.WORD_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .start(start), .cfg_mode(cfg_mode),
      .cfg_seed(cfg_seed), .cfg_first(cfg_first), .cfg_num_beats(cfg_num_beats),
      .beat_cnt(beat_cnt), .err_cnt(err_cnt), .data_err(data_err),
      .proto_err(proto_err), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a handshake seen at a falling edge completes on the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (hs_pend) begin
         if (sb_q.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_beat_cnt", beat_cnt, e.beat);
            check("sb_err_cnt", err_cnt, e.err);
            check("sb_data_err", data_err, e.derr);
         end
      end
      hs_pend = in_valid && in_ready && rst_n;
      if (busy && ncap < 64) begin
         cap[ncap] = in_ready;
         ncap++;
      end
   end

   task automatic add_beat(input logic [7:0] d, input logic [15:0] b,
                           input logic [15:0] e, input logic de);
      exp_t x;
      x.beat = b; x.err = e; x.derr = de;
      tx_data.push_back(d);
      tx_exp.push_back(x);
   endtask

   task automatic clear_tx();
      tx_data.delete();
      tx_exp.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 of the start edge.
   task automatic do_start(input logic [1:0] mode, input logic [15:0] seed,
                           input logic [7:0] first, input logic [15:0] num);
      cfg_mode = mode; cfg_seed = seed; cfg_first = first; cfg_num_beats = num;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ncap = 0;
      cap = '0;
   endtask

   // Presents each word and holds it until accepted; valid stays high between words.
   task automatic send(input int n);
      bit ok;
      int waited;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = tx_data[i];
         waited   = 0;
         ok       = 1'b0;
         while (!ok && waited < 100) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) begin
               @(posedge clk); #1;
            end
            waited++;
         end
         if (!ok) begin
            check("beat_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
         end
         sb_q.push_back(tx_exp[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic end_test();
      @(posedge clk); #1;
      check("sb_drained", sb_q.size(), 64'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_in_ready", in_ready, 64'd0);
      check("rst_busy", busy, 64'd0);
      check("rst_done", done, 64'd0);
      check("rst_beat_cnt", beat_cnt, 64'd0);
      check("rst_err_cnt", err_cnt, 64'd0);
      check("rst_data_err", data_err, 64'd0);
      check("rst_proto_err", proto_err, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [0:33] lfsr_bits;
      logic [63:0] lfsr_exp;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;

      // Mode 00 back-to-back; num_beats changed after start must not matter
      clear_tx();
      add_beat(8'h05, 16'd1, 16'd0, 1'b0);
      add_beat(8'h06, 16'd2, 16'd0, 1'b0);
      add_beat(8'h07, 16'd3, 16'd0, 1'b0);
      add_beat(8'h08, 16'd4, 16'd0, 1'b0);
      do_start(2'b00, 16'h0000, 8'h05, 16'd4);
      cfg_num_beats = 16'd2;
      send(4);
      @(negedge clk);
      check("m0_done", done, 64'd1);
      check("m0_in_ready_after", in_ready, 64'd0);
      check("m0_beat_cnt", beat_cnt, 64'd4);
      check("m0_err_cnt", err_cnt, 64'd0);
      check("m0_proto_err", proto_err, 64'd0);
      check("m0_run_cycles", ncap, 64'd4);
      check("m0_ready_pattern", cap, 64'hF);
      end_test();

      // Mode 01 toggle with data wrap FE,FF,00,01
      clear_tx();
      add_beat(8'hFE, 16'd1, 16'd0, 1'b0);
      add_beat(8'hFF, 16'd2, 16'd0, 1'b0);
      add_beat(8'h00, 16'd3, 16'd0, 1'b0);
      add_beat(8'h01, 16'd4, 16'd0, 1'b0);
      do_start(2'b01, 16'h0000, 8'hFE, 16'd4);
      send(4);
      @(negedge clk);
      check("m1_done", done, 64'd1);
      check("m1_beat_cnt", beat_cnt, 64'd4);
      check("m1_err_cnt", err_cnt, 64'd0);
      check("m1_run_cycles", ncap, 64'd7);
      check("m1_ready_pattern", cap, 64'b1010101);
      end_test();

      // Data mismatch and resynchronisation: 00,01,09,0A
      clear_tx();
      add_beat(8'h00, 16'd1, 16'd0, 1'b0);
      add_beat(8'h01, 16'd2, 16'd0, 1'b0);
      add_beat(8'h09, 16'd3, 16'd1, 1'b1);
      add_beat(8'h0A, 16'd4, 16'd1, 1'b1);
      do_start(2'b00, 16'h0000, 8'h00, 16'd4);
      send(4);
      @(negedge clk);
      check("mm_done", done, 64'd1);
      check("mm_err_cnt", err_cnt, 64'd1);
      check("mm_data_err", data_err, 64'd1);
      check("mm_beat_cnt", beat_cnt, 64'd4);
      end_test();

      // Mode 11 stall: data changes while stalled, then start is ignored in RUN
      do_start(2'b11, 16'h0000, 8'h3C, 16'd4);
      in_valid = 1'b1; in_data = 8'h3C;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_data = 8'h3D;
      @(negedge clk);
      check("st_proto_hold_ok", proto_err, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("st_proto_err", proto_err, 64'd1);
      check("st_beat_cnt", beat_cnt, 64'd0);
      check("st_in_ready", in_ready, 64'd0);
      @(posedge clk); #1;
      do_start(2'b00, 16'h0000, 8'h00, 16'd1);
      @(negedge clk);
      check("st_start_ignored_busy", busy, 64'd1);
      check("st_start_ignored_proto", proto_err, 64'd1);
      check("st_start_ignored_ready", in_ready, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      end_test();

      // Mode 10 with seed 0 -> ACE1; ready stream s0..s33 hand-derived from the taps
      clear_tx();
      for (int i = 0; i < 16; i++) add_beat(8'h40 + 8'(i), 16'(i + 1), 16'd0, 1'b0);
      do_start(2'b10, 16'h0000, 8'h40, 16'd16);
      send(16);
      @(negedge clk);
      lfsr_bits = 34'b1000011100110101_0100010011100010_11;
      lfsr_exp  = '0;
      for (int i = 0; i < 34; i++) lfsr_exp[i] = lfsr_bits[i];
      check("lf_run_cycles", ncap, 64'd34);
      check("lf_ready_pattern", cap, lfsr_exp);
      check("lf_done", done, 64'd1);
      check("lf_beat_cnt", beat_cnt, 64'd16);
      check("lf_in_ready_after", in_ready, 64'd0);
      end_test();

      // Reset after 2 of 8 beats with a third beat in flight, then a clean re-run
      clear_tx();
      for (int i = 0; i < 8; i++) add_beat(8'h20 + 8'(i), 16'(i + 1), 16'd0, 1'b0);
      do_start(2'b00, 16'h0000, 8'h20, 16'd8);
      send(2);
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h22;
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      end_test();
      do_start(2'b00, 16'h0000, 8'h20, 16'd8);
      send(8);
      @(negedge clk);
      check("rr_done", done, 64'd1);
      check("rr_beat_cnt", beat_cnt, 64'd8);
      check("rr_err_cnt", err_cnt, 64'd0);
      end_test();

      // num_beats == 0 goes straight to DONE with ready low
      do_start(2'b00, 16'h0000, 8'h00, 16'd0);
      @(negedge clk);
      check("z_done", done, 64'd1);
      check("z_busy", busy, 64'd0);
      check("z_in_ready", in_ready, 64'd0);
      check("z_beat_cnt", beat_cnt, 64'd0);
      end_test();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
